// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo_pkg: shared types and helpers for the packet FIFO.
// The WR_DROP state exists only when PKT_FIFO_OVERFLOW_DROP_EN is defined.
package pkt_fifo_pkg;

    typedef struct packed {
        logic sop;
        logic eop;
    } word_tag_t;

    localparam int unsigned TAG_W = $bits(word_tag_t);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_OPEN = 2'd1
`ifdef PKT_FIFO_OVERFLOW_DROP_EN
        ,
        WR_DROP = 2'd2
`endif
    } wr_state_e;

    // Wrap-bit pointers subtract modulo 2**width; callers truncate.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return a - b;
    endfunction

endpackage

// File: rtl/pkt_fifo_if.sv
// pkt_fifo_if: write, read and status signals of the packet FIFO.
// slave is the FIFO side, master the producer/consumer side.
interface pkt_fifo_if
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned PKT_CNT_WIDTH = 8
);

    logic [DATA_WIDTH-1:0]    data_in;
    logic                     data_in_enable;
    logic                     data_in_start;
    logic                     data_in_end;
    logic                     data_in_abort;
    logic                     full;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     data_out_enable;
    logic                     data_out_valid;
    logic                     data_out_start;
    logic                     data_out_end;
    logic                     data_out_rewind;
    logic                     empty;
    logic [ADDR_WIDTH:0]      count;
    logic [PKT_CNT_WIDTH-1:0] packet_count;
    logic                     overflow;

    modport slave (
        input  data_in,
        input  data_in_enable,
        input  data_in_start,
        input  data_in_end,
        input  data_in_abort,
        input  data_out_enable,
        input  data_out_rewind,
        output full,
        output data_out,
        output data_out_valid,
        output data_out_start,
        output data_out_end,
        output empty,
        output count,
        output packet_count,
        output overflow
    );

    modport master (
        output data_in,
        output data_in_enable,
        output data_in_start,
        output data_in_end,
        output data_in_abort,
        output data_out_enable,
        output data_out_rewind,
        input  full,
        input  data_out,
        input  data_out_valid,
        input  data_out_start,
        input  data_out_end,
        input  empty,
        input  count,
        input  packet_count,
        input  overflow
    );

endinterface

// File: rtl/pkt_fifo_ram.sv
// pkt_fifo_ram: simple dual-port RAM, synchronous write and 1-cycle read.
// A same-cycle write to the read address is forwarded (write-first).
module pkt_fifo_ram
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: single-clock packet FIFO with commit, abort and read rewind.
// Define PKT_FIFO_OVERFLOW_DROP_EN to drop packets that overflow the buffer.
module pkt_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned PKT_CNT_WIDTH = 8
) (
    input  logic      clock,
    input  logic      reset_n,
    pkt_fifo_if.slave bus
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned WORD_W = DATA_WIDTH + TAG_W;

    typedef logic [ADDR_WIDTH:0]      ptr_t;
    typedef logic [PKT_CNT_WIDTH-1:0] cnt_t;

    ptr_t wr_q, wr_d;
    ptr_t commit_q, commit_d;
    ptr_t rd_q, rd_d;
    ptr_t rd_pkt_q, rd_pkt_d;
    ptr_t rel_q, rel_d;
    cnt_t pkt_q, pkt_d;

    wr_state_e st_q, st_d;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    word_tag_t             tag_q, tag_d;
    logic                  valid_q;

    ptr_t              used;
    ptr_t              waddr;
    logic              full;
    logic              empty;
    logic              we;
    logic              rd_acc;
    logic              pkt_inc;
    logic              pkt_dec;
    logic              in_drop;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    word_tag_t         rtag;

`ifdef PKT_FIFO_OVERFLOW_DROP_EN
    logic ovf_q, ovf_d;
`endif

    assign used  = ptr_t'(ptr_diff(32'(wr_q), 32'(rel_q)));
    assign full  = (used == ptr_t'(DEPTH));
    assign empty = (rd_q == commit_q);

    assign wdata = {bus.data_in, bus.data_in_start, bus.data_in_end};
    assign rtag  = word_tag_t'(rdata[TAG_W-1:0]);

`ifdef PKT_FIFO_OVERFLOW_DROP_EN
    assign in_drop = (st_q == WR_DROP) && !bus.data_in_start;
`else
    assign in_drop = 1'b0;
`endif

    // Writer: abort beats write, start inside a packet restarts it.
    always_comb begin
        wr_d     = wr_q;
        commit_d = commit_q;
        st_d     = st_q;
        we       = 1'b0;
        waddr    = wr_q;
        pkt_inc  = 1'b0;
`ifdef PKT_FIFO_OVERFLOW_DROP_EN
        ovf_d    = 1'b0;
`endif
        if (bus.data_in_abort) begin
            wr_d = commit_q;
            st_d = WR_IDLE;
        end else if (bus.data_in_enable) begin
            if (in_drop) begin
                if (bus.data_in_end) begin
                    st_d = WR_IDLE;
                end
            end else if (!full) begin
                we = 1'b1;
                if (bus.data_in_start && (st_q == WR_OPEN)) begin
                    waddr = commit_q;
                end
                wr_d = waddr + ptr_t'(1);
                if (bus.data_in_end) begin
                    commit_d = wr_d;
                    pkt_inc  = 1'b1;
                    st_d     = WR_IDLE;
                end else begin
                    st_d = WR_OPEN;
                end
            end else begin
`ifdef PKT_FIFO_OVERFLOW_DROP_EN
                ovf_d = 1'b1;
                if (st_q != WR_IDLE) begin
                    wr_d = commit_q;
                end
                if ((st_q != WR_IDLE) && !bus.data_in_end) begin
                    st_d = WR_DROP;
                end else begin
                    st_d = WR_IDLE;
                end
`endif
            end
        end
    end

    assign rd_acc = bus.data_out_enable && !empty && !bus.data_out_rewind;

    // Reader: rdata already holds mem[rd_q], so markers act on accept.
    always_comb begin
        rd_d     = rd_q;
        rd_pkt_d = rd_pkt_q;
        rel_d    = rel_q;
        pkt_dec  = 1'b0;
        dout_d   = dout_q;
        tag_d    = tag_q;
        if (bus.data_out_rewind) begin
            rd_d = rd_pkt_q;
        end else if (rd_acc) begin
            rd_d   = rd_q + ptr_t'(1);
            dout_d = rdata[WORD_W-1:TAG_W];
            tag_d  = rtag;
            if (rtag.sop) begin
                rd_pkt_d = rd_q;
            end
            if (rtag.eop) begin
                rel_d    = rd_d;
                rd_pkt_d = rd_d;
                pkt_dec  = 1'b1;
            end
        end
    end

    always_comb begin
        pkt_d = pkt_q;
        if (pkt_inc && !pkt_dec && !(&pkt_q)) begin
            pkt_d = pkt_q + cnt_t'(1);
        end else if (pkt_dec && !pkt_inc && (pkt_q != '0)) begin
            pkt_d = pkt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q     <= '0;
            commit_q <= '0;
            rd_q     <= '0;
            rd_pkt_q <= '0;
            rel_q    <= '0;
            pkt_q    <= '0;
            st_q     <= WR_IDLE;
            dout_q   <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            commit_q <= commit_d;
            rd_q     <= rd_d;
            rd_pkt_q <= rd_pkt_d;
            rel_q    <= rel_d;
            pkt_q    <= pkt_d;
            st_q     <= st_d;
            dout_q   <= dout_d;
            tag_q    <= tag_d;
            valid_q  <= rd_acc;
        end
    end

`ifdef PKT_FIFO_OVERFLOW_DROP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif

    // Read address is the next pointer so rdata tracks mem[rd_q].
    pkt_fifo_ram #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clock),
        .rst_n   (reset_n),
        .we_i    (we),
        .waddr_i (waddr[ADDR_WIDTH-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_d[ADDR_WIDTH-1:0]),
        .rdata_o (rdata)
    );

    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.count          = used;
    assign bus.packet_count   = pkt_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_start = tag_q.sop;
    assign bus.data_out_end   = tag_q.eop;
    assign bus.data_out_valid = valid_q;

endmodule

// File: tb/tb_pkt_fifo.sv
// tb_pkt_fifo: directed and random checks of pkt_fifo against a queue model.
// Define PKT_FIFO_OVERFLOW_DROP_EN to also cover the overflow drop path.
module tb_pkt_fifo;
    import pkt_fifo_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int CW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_err   = 0;

    // Model: stored words from the release point up to the write point.
    logic [DW+1:0] q[$];
    int            ncommit;
    int            rd_i;
    int            pk_i;
    bit            m_valid;
    bit            m_ovf;
    bit            m_drop;
    logic [DW+1:0] m_out;

    always #5 clock = ~clock;

    pkt_fifo_if #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .PKT_CNT_WIDTH (CW)
    ) bus ();

    pkt_fifo #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .PKT_CNT_WIDTH (CW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_pkts();
        int n = 0;
        for (int i = rd_i; i < ncommit; i++) begin
            if (q[i][0]) n++;
        end
        return n;
    endfunction

    task automatic m_reset();
        q.delete();
        ncommit = 0;
        rd_i    = 0;
        pk_i    = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 1'b0;
        m_out   = '0;
    endtask

    task automatic m_trunc();
        while (q.size() > ncommit) void'(q.pop_back());
    endtask

    task automatic m_step();
        bit            wen, st, en, ab, ren, rw, rd_ok, full_pre, open;
        logic [DW+1:0] w;
        wen = bus.data_in_enable;
        st  = bus.data_in_start;
        en  = bus.data_in_end;
        ab  = bus.data_in_abort;
        ren = bus.data_out_enable;
        rw  = bus.data_out_rewind;
        rd_ok    = ren && !rw && (rd_i < ncommit);
        full_pre = (q.size() == DEPTH);
        open     = (q.size() > ncommit);
        m_ovf    = 1'b0;
        if (ab) begin
            m_trunc();
            m_drop = 1'b0;
        end else if (wen) begin
`ifdef PKT_FIFO_OVERFLOW_DROP_EN
            if (m_drop && !st) begin
                if (en) m_drop = 1'b0;
            end else
`endif
            if (!full_pre) begin
                if (st && open) m_trunc();
                q.push_back({bus.data_in, st, en});
                if (en) ncommit = q.size();
                m_drop = 1'b0;
            end
`ifdef PKT_FIFO_OVERFLOW_DROP_EN
            else begin
                m_ovf = 1'b1;
                if ((open || m_drop) && !en) begin
                    m_trunc();
                    m_drop = 1'b1;
                end else begin
                    if (open) m_trunc();
                    m_drop = 1'b0;
                end
            end
`endif
        end
        m_valid = rd_ok;
        if (rw) begin
            rd_i = pk_i;
        end else if (rd_ok) begin
            w     = q[rd_i];
            m_out = w;
            if (w[1]) pk_i = rd_i;
            rd_i++;
            if (w[0]) begin
                repeat (rd_i) void'(q.pop_front());
                ncommit -= rd_i;
                rd_i = 0;
                pk_i = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("empty", 32'(bus.empty), 32'(rd_i == ncommit));
        chk("full", 32'(bus.full), 32'(q.size() == DEPTH));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("pkts", 32'(bus.packet_count), 32'(m_pkts()));
        chk("valid", 32'(bus.data_out_valid), 32'(m_valid));
        chk("dout", 32'({bus.data_out, bus.data_out_start,
                         bus.data_out_end}), 32'(m_out));
        chk("ovf", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input bit wen, input bit st, input bit en,
                       input bit ab, input logic [DW-1:0] d,
                       input bit ren, input bit rw);
        bus.data_in_enable  = wen;
        bus.data_in_start   = st;
        bus.data_in_end     = en;
        bus.data_in_abort   = ab;
        bus.data_in         = d;
        bus.data_out_enable = ren;
        bus.data_out_rewind = rw;
        @(posedge clock);
        m_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic wr(input bit st, input bit en, input logic [DW-1:0] d);
        cyc(1'b1, st, en, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] dout_w();
        return 32'({bus.data_out, bus.data_out_start, bus.data_out_end});
    endfunction

    bit            r_wen, r_st, r_en, r_ab, r_ren, r_rw;
    logic [DW-1:0] r_d;

    initial begin
        bus.data_in_enable  = 1'b0;
        bus.data_in_start   = 1'b0;
        bus.data_in_end     = 1'b0;
        bus.data_in_abort   = 1'b0;
        bus.data_in         = '0;
        bus.data_out_enable = 1'b0;
        bus.data_out_rewind = 1'b0;
        m_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset_n = 1'b1;

        // three-word packet
        wr(1'b1, 1'b0, 8'hA1);
        wr(1'b0, 1'b0, 8'hA2);
        wr(1'b0, 1'b1, 8'hA3);
        chk("t1_empty", 32'(bus.empty), 32'd0);
        chk("t1_pkts", 32'(bus.packet_count), 32'd1);
        rd();
        chk("t1_a1", dout_w(), {22'd0, 8'hA1, 2'b10});
        rd();
        rd();
        chk("t1_a3", dout_w(), {22'd0, 8'hA3, 2'b01});

        // abort then one-word packet
        wr(1'b1, 1'b0, 8'hB1);
        wr(1'b0, 1'b0, 8'hB2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        wr(1'b1, 1'b1, 8'hC1);
        chk("t2_count", 32'(bus.count), 32'd1);
        chk("t2_pkts", 32'(bus.packet_count), 32'd1);
        rd();
        chk("t2_c1", dout_w(), {22'd0, 8'hC1, 2'b11});
        rd();
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // rewind mid-packet
        wr(1'b1, 1'b0, 8'hD1);
        wr(1'b0, 1'b0, 8'hD2);
        wr(1'b0, 1'b0, 8'hD3);
        wr(1'b0, 1'b1, 8'hD4);
        rd();
        rd();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        rd();
        chk("t3_d1", dout_w(), {22'd0, 8'hD1, 2'b10});
        rd();
        rd();
        chk("t3_count", 32'(bus.count), 32'd4);
        rd();
        chk("t3_d4", dout_w(), {22'd0, 8'hD4, 2'b01});
        chk("t3_free", 32'(bus.count), 32'd0);

        // full, ignored write, then pointer wraps
        wr(1'b1, 1'b0, 8'h11);
        wr(1'b0, 1'b1, 8'h12);
        wr(1'b1, 1'b0, 8'h13);
        wr(1'b0, 1'b1, 8'h14);
        wr(1'b1, 1'b1, 8'h15);
        chk("t4_full", 32'(bus.full), 32'd1);
        chk("t4_count", 32'(bus.count), 32'd4);
        rd();
        rd();
        chk("t4_nfull", 32'(bus.full), 32'd0);
        rd();
        rd();
        for (int i = 0; i < 12; i++) begin
            wr(1'b1, 1'b0, 8'(2 * i));
            wr(1'b0, 1'b1, 8'(2 * i + 1));
            rd();
            rd();
            chk("t4_wrap", dout_w(), 32'({8'(2 * i + 1), 2'b01}));
        end

        // commit and end-read in the same cycle
        wr(1'b1, 1'b1, 8'hF1);
        wr(1'b1, 1'b0, 8'hE1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hE2, 1'b1, 1'b0);
        chk("t5_pkts", 32'(bus.packet_count), 32'd1);
        chk("t5_f1", dout_w(), {22'd0, 8'hF1, 2'b11});
        rd();
        rd();

        // reset mid-packet and mid-read
        wr(1'b1, 1'b0, 8'h21);
        wr(1'b0, 1'b1, 8'h22);
        wr(1'b1, 1'b0, 8'h23);
        rd();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(negedge clock);
        reset_n = 1'b1;
        wr(1'b1, 1'b1, 8'h77);
        rd();
        chk("t6_after", dout_w(), {22'd0, 8'h77, 2'b11});

`ifdef PKT_FIFO_OVERFLOW_DROP_EN
        // oversized packet is dropped
        wr(1'b1, 1'b0, 8'h60);
        wr(1'b0, 1'b0, 8'h61);
        wr(1'b0, 1'b0, 8'h62);
        wr(1'b0, 1'b0, 8'h63);
        wr(1'b0, 1'b0, 8'h64);
        chk("t7_ovf", 32'(bus.overflow), 32'd1);
        chk("t7_count", 32'(bus.count), 32'd0);
        wr(1'b0, 1'b1, 8'h65);
        chk("t7_ovf0", 32'(bus.overflow), 32'd0);
        wr(1'b1, 1'b1, 8'h66);
        rd();
        chk("t7_next", dout_w(), {22'd0, 8'h66, 2'b11});
`endif

        for (int i = 0; i < 3000; i++) begin
            r_wen = ($urandom_range(0, 99) < 60);
            r_st  = ($urandom_range(0, 99) < 25);
            r_en  = ($urandom_range(0, 99) < 30);
            r_ab  = ($urandom_range(0, 99) < 4);
            r_ren = ($urandom_range(0, 99) < 50);
            r_rw  = ($urandom_range(0, 99) < 6);
            r_d   = 8'($urandom);
            cyc(r_wen, r_st, r_en, r_ab, r_d, r_ren, r_rw);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
